// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: sequencer between uart_rx, an external combinational ALU and
// uart_tx. It gathers operand A, operand B and an opcode byte, lets the ALU
// settle for one cycle, captures the result and launches one uart_tx transfer.
// A partially received frame is abandoned after an inter-byte timeout. Bytes
// that arrive while a result is in flight are dropped and flagged as overruns.
module uart_alu_ctrl #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rx_done,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_tx_done,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [OP_W-1:0]   o_alu_op,
  output logic              o_tx_start,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_busy,
  output logic              o_timeout,
  output logic              o_overrun
);

  typedef enum logic [2:0] {
    ST_GET_A,
    ST_GET_B,
    ST_GET_OP,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  state_t          r_state;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_expired;

  // Inter-byte gap has used up its whole budget on this cycle
  assign w_expired = (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Frame sequencer; every output is a register updated here. o_busy is set
  // from the state being entered so it tracks the current state exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_GET_A;
      r_to_cnt   <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
      case (r_state)
        ST_GET_A: begin
          if (i_rx_done) begin
            o_alu_a  <= i_rx_data;
            r_to_cnt <= '0;
            o_busy   <= 1'b1;
            r_state  <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (i_rx_done) begin
            o_alu_b  <= i_rx_data;
            r_to_cnt <= '0;
            r_state  <= ST_GET_OP;
          end else if (w_expired) begin
            o_timeout <= 1'b1;
            r_to_cnt  <= '0;
            o_busy    <= 1'b0;
            r_state   <= ST_GET_A;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_GET_OP: begin
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[OP_W-1:0];
            r_to_cnt <= '0;
            r_state  <= ST_EXEC;
          end else if (w_expired) begin
            o_timeout <= 1'b1;
            r_to_cnt  <= '0;
            o_busy    <= 1'b0;
            r_state   <= ST_GET_A;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_EXEC: begin
          o_tx_data <= i_alu_result;
          o_overrun <= i_rx_done;
          r_state   <= ST_SEND;
        end
        ST_SEND: begin
          o_tx_start <= 1'b1;
          o_overrun  <= i_rx_done;
          r_state    <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          o_overrun <= i_rx_done;
          if (i_tx_done) begin
            o_busy  <= 1'b0;
            r_state <= ST_GET_A;
          end
        end
        default: begin
          r_to_cnt <= '0;
          o_busy   <= 1'b0;
          r_state  <= ST_GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl: table-driven frames plus hand-written
// sequences for timeout, expiry-edge acceptance, overrun and async reset.
module tb_uart_alu_ctrl;

  localparam int DATA_W  = 8;
  localparam int OP_W    = 6;
  localparam int TIMEOUT = 50;
  localparam int TO_W    = 6;

  logic              clk;
  logic              resetN;
  logic              rxDone;
  logic [DATA_W-1:0] rxData;
  logic [DATA_W-1:0] aluResult;
  logic              txDone;
  logic [DATA_W-1:0] aluA;
  logic [DATA_W-1:0] aluB;
  logic [OP_W-1:0]   aluOp;
  logic              txStart;
  logic [DATA_W-1:0] txData;
  logic              busy;
  logic              timeoutPulse;
  logic              overrun;

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int timeoutCount = 0;
  int overrunCount = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] result;
  } vec_t;

  vec_t vecs [5];

  uart_alu_ctrl #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clk         (clk),
    .reset       (resetN),
    .i_rx_done   (rxDone),
    .i_rx_data   (rxData),
    .i_alu_result(aluResult),
    .i_tx_done   (txDone),
    .o_alu_a     (aluA),
    .o_alu_b     (aluB),
    .o_alu_op    (aluOp),
    .o_tx_start  (txStart),
    .o_tx_data   (txData),
    .o_busy      (busy),
    .o_timeout   (timeoutPulse),
    .o_overrun   (overrun)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Small ALU stand-in: 0x20 adds, 0x22 subtracts, anything else XORs
  always_comb begin
    case (aluOp)
      6'h20:   aluResult = aluA + aluB;
      6'h22:   aluResult = aluA - aluB;
      default: aluResult = aluA ^ aluB;
    endcase
  end

  // Pulse counters sampled mid-cycle, used for whole-sequence checks
  always @(negedge clk) begin
    if (txStart)      startCount++;
    if (timeoutPulse) timeoutCount++;
    if (overrun)      overrunCount++;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One received byte: strobe is high for exactly one cycle, sampled at the
  // following rising edge; returns 1ns after that edge.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    rxData = b;
    rxDone = 1'b1;
    @(posedge clk); #1;
    rxDone = 1'b0;
  endtask

  // Called just after the opcode byte was sampled (cycle N). Expects the result
  // latched by N+2, tx_start in N+3, and answers with tx_done one cycle later.
  task automatic completeFrame(input logic [7:0] expResult);
    @(negedge clk);
    checkOutput("start_exec", txStart, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("start_send", txStart, 0);
    checkOutput("data_send", txData, expResult);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("start_pulse", txStart, 1);
    checkOutput("busy_wait", busy, 1);
    checkOutput("timeout_wait", timeoutPulse, 0);
    @(posedge clk); #1;
    txDone = 1'b1;
    @(negedge clk);
    checkOutput("start_end", txStart, 0);
    checkOutput("data_hold", txData, expResult);
    @(posedge clk); #1;
    txDone = 1'b0;
    @(negedge clk);
    checkOutput("busy_idle", busy, 0);
  endtask

  task automatic runFrame(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] expResult);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(op);
    completeFrame(expResult);
  endtask

  initial begin
    int snapStart;
    int snapTimeout;
    int snapOverrun;

    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
    vecs[1] = '{8'hFF, 8'h01, 8'h20, 8'h00};
    vecs[2] = '{8'h10, 8'h03, 8'h22, 8'h0D};
    vecs[3] = '{8'h0F, 8'hF0, 8'h05, 8'hFF};
    vecs[4] = '{8'h07, 8'h07, 8'hE0, 8'h0E};

    resetN = 1'b0;
    rxDone = 1'b0;
    rxData = '0;
    txDone = 1'b0;

    // Reset state
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_start", txStart, 0);
    checkOutput("rst_alu_a", aluA, 0);
    checkOutput("rst_alu_op", aluOp, 0);
    checkOutput("rst_tx_data", txData, 0);
    checkOutput("rst_timeout", timeoutPulse, 0);
    checkOutput("rst_overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;

    // Stray tx_done while idle is ignored
    @(posedge clk); #1;
    txDone = 1'b1;
    @(posedge clk); #1;
    txDone = 1'b0;
    @(negedge clk);
    checkOutput("stray_busy", busy, 0);
    checkOutput("stray_start", txStart, 0);

    // Back-to-back frames from the table
    snapStart   = startCount;
    snapTimeout = timeoutCount;
    snapOverrun = overrunCount;
    for (int i = 0; i < 5; i++) begin
      runFrame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].result);
      checkOutput("vec_alu_a", aluA, vecs[i].a);
      checkOutput("vec_alu_b", aluB, vecs[i].b);
      checkOutput("vec_alu_op", aluOp, 32'(vecs[i].op[5:0]));
    end
    checkOutput("b2b_starts", startCount - snapStart, 5);
    checkOutput("b2b_timeouts", timeoutCount - snapTimeout, 0);
    checkOutput("b2b_overruns", overrunCount - snapOverrun, 0);

    // Timeout after a lone operand A
    applyStimulus(8'h11);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("to_before", timeoutPulse, 0);
    checkOutput("to_busy_before", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("to_pulse", timeoutPulse, 1);
    checkOutput("to_busy_after", busy, 0);
    checkOutput("to_keep_a", aluA, 8'h11);
    checkOutput("to_keep_b", aluB, 8'h07);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("to_pulse_end", timeoutPulse, 0);
    runFrame(8'h01, 8'h02, 8'h20, 8'h03);

    // Byte arriving on the exact expiry cycle wins
    snapTimeout = timeoutCount;
    applyStimulus(8'h21);
    repeat (TIMEOUT - 2) @(posedge clk);
    #1;
    applyStimulus(8'h04);
    @(negedge clk);
    checkOutput("edge_no_timeout", timeoutPulse, 0);
    checkOutput("edge_busy", busy, 1);
    checkOutput("edge_alu_b", aluB, 8'h04);
    applyStimulus(8'h20);
    completeFrame(8'h25);
    checkOutput("edge_timeouts", timeoutCount - snapTimeout, 0);

    // Overrun: extra byte while waiting for tx_done
    applyStimulus(8'h30);
    applyStimulus(8'h02);
    applyStimulus(8'h22);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rxData = 8'h99;
    rxDone = 1'b1;
    @(negedge clk);
    checkOutput("ovr_start", txStart, 1);
    @(posedge clk); #1;
    rxDone = 1'b0;
    @(negedge clk);
    checkOutput("ovr_pulse", overrun, 1);
    checkOutput("ovr_tx_data", txData, 8'h2E);
    checkOutput("ovr_busy", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ovr_pulse_end", overrun, 0);
    @(posedge clk); #1;
    txDone = 1'b1;
    @(posedge clk); #1;
    txDone = 1'b0;
    @(negedge clk);
    checkOutput("ovr_idle", busy, 0);
    checkOutput("ovr_keep_a", aluA, 8'h30);
    runFrame(8'h02, 8'h02, 8'h20, 8'h04);

    // rx_done together with tx_done: dropped, flagged, still returns idle
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    applyStimulus(8'h20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rxData = 8'h55;
    rxDone = 1'b1;
    txDone = 1'b1;
    @(posedge clk); #1;
    rxDone = 1'b0;
    txDone = 1'b0;
    @(negedge clk);
    checkOutput("both_overrun", overrun, 1);
    checkOutput("both_busy", busy, 0);
    checkOutput("both_tx_data", txData, 8'h02);
    runFrame(8'h09, 8'h04, 8'h22, 8'h05);

    // Async reset while waiting for the opcode
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    #2 resetN = 1'b0;
    #1;
    checkOutput("rst_op_busy", busy, 0);
    checkOutput("rst_op_a", aluA, 0);
    checkOutput("rst_op_b", aluB, 0);
    snapStart = startCount;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_op_nostart", startCount - snapStart, 0);
    checkOutput("rst_op_idle", busy, 0);

    // Async reset in the tx_start cycle, before the pulse can be observed
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    applyStimulus(8'h20);
    snapStart = startCount;
    @(posedge clk); #1;
    @(posedge clk); #2;
    resetN = 1'b0;
    #1;
    checkOutput("rst_tx_start", txStart, 0);
    checkOutput("rst_tx_data", txData, 0);
    checkOutput("rst_tx_busy", busy, 0);
    checkOutput("rst_tx_op", aluOp, 0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tx_nostart", startCount - snapStart, 0);
    runFrame(8'h0A, 8'h0B, 8'h20, 8'h15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
